fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the fetch/execute pipeline register.
- Generates the fetch PC and issues in-order requests to a variable-latency instruction memory.
- Buffers returned instructions, with their PCs, in a small in-order fetch queue.
- Presents one instruction per cycle to the IR/PC pipeline registers, honouring downstream stall and branch redirect (flush).

Parameters:
- DEPTH, 4, fetch queue entries; also the maximum number of outstanding memory requests (power of two, ≥2).
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP, 32'h0000_0013, instruction driven on inst when no valid instruction is presented (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  32  fetch address; always word-aligned.
- imem_resp_valid  in  1  response valid; responses return in request order, latency ≥1 cycle.
- imem_resp_data  in  32  instruction word.
- redirect_valid  in  1  branch taken; flush and restart fetching.
- redirect_pc  in  32  new fetch address.
- stall  in  1  downstream holds; the presented instruction is not consumed.
- inst_valid  out  1  inst/inst_pc carry a real instruction.
- inst  out  32  instruction to the IR pipeline register.
- inst_pc  out  32  PC of inst.

Behaviour:
- Reset, asynchronous and active-high, forces:
  - fetch_pc=RESET_PC, queue empty, drop_cnt=0.
  - imem_req_valid=0, inst_valid=0, inst=NOP, inst_pc=0.
- A reset asserted mid-operation discards every queued and in-flight request. Responses arriving during reset are ignored.
- Queue entry fields: pc[31:0], data[31:0], filled bit. Pointers are head, tail and fill, each log2(DEPTH) bits and wrapping modulo DEPTH. alloc_cnt ranges 0..DEPTH.
- Request issue:
  - imem_req_valid = !reset && !redirect_valid && (alloc_cnt + drop_cnt < DEPTH).
  - imem_req_addr = fetch_pc.
  - On valid&&ready: allocate the entry at tail (pc=fetch_pc, filled=0), tail++, fetch_pc += 4 (wraps modulo 2^32).
  - imem_req_valid, once raised, is held with a stable address until accepted or until a redirect occurs.
- Response:
  - If drop_cnt>0: discard the response and decrement drop_cnt.
  - Otherwise write data into the entry at fill, set filled, fill++.
- Output:
  - inst_valid = head entry allocated && filled.
  - inst and inst_pc come from the head entry, combinationally.
  - When inst_valid=0, inst=NOP and inst_pc holds its last value.
- Consume: when inst_valid && !stall, free the head entry and increment head.
- Throughput: with 1-cycle memory latency and no stall, one instruction per cycle in steady state. The first instruction after reset or redirect appears 2 cycles after the request is accepted.
- Redirect, when redirect_valid=1:
  - Next edge: fetch_pc = {redirect_pc[31:2],2'b00}, queue cleared (head=tail=fill, alloc_cnt=0).
  - drop_cnt = drop_cnt + (allocated-but-unfilled entries) − (1 if a response was being dropped this cycle, else 0).
  - No request is issued in the redirect cycle; fetching resumes the following cycle.
- Simultaneous events:
  - Redirect + response same cycle: the response is dropped. If it would have filled an entry, it is not added to drop_cnt.
  - Redirect + consume same cycle: the redirect wins and the whole queue is cleared. The downstream register still captures the presented instruction that edge; downstream squashes it.
  - Consume + allocate same cycle with a full queue: no allocation occurs, because the credit check uses the current-cycle alloc_cnt.
  - Response with no unfilled entry and drop_cnt=0: protocol error; state unchanged.
- Full: alloc_cnt+drop_cnt==DEPTH → imem_req_valid=0.
- Empty: inst_valid=0 and inst=NOP (bubble).

Test Plan:
- Reset release, 1-cycle memory, stall=0 → requests at 0x0,0x4,0x8…; inst_valid rises on the 3rd cycle after reset with inst_pc=0x0; then one instruction per cycle in consecutive PC order.
- Hold stall=1 for 10 cycles with DEPTH=4 → at most 4 requests accepted, then imem_req_valid=0; inst/inst_pc stay constant. Deassert stall → entries drain in order 0x0,0x4,0x8,0xC with no loss.
- 3-cycle memory latency, 2 requests in flight, redirect_pc=0x100 → both stale responses are dropped (drop_cnt 2→0); the first new inst_pc=0x100 with data from the 0x100 request.
- redirect_pc=0x203 → imem_req_addr=0x200.
- Redirect in the same cycle as a response and a consume → queue empties next cycle, inst=0x00000013, inst_valid=0; no stale instruction appears later.
- Randomized imem_req_ready/latency/stall/redirect for 10k cycles against a reference PC model → every presented (inst_pc, inst) matches memory[inst_pc], PCs are sequential between redirects, outstanding requests never exceed DEPTH.
- Assert reset mid-stream with 2 requests in flight → outputs return to reset values immediately; after release, fetching restarts at RESET_PC and late responses are ignored.

Source files
------------

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory request/response bundle between fetch_unit and imem
interface fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - fetch PC generation, in-order imem requests and fetch queue feeding the IR/PC registers
module fetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic                clk,
    input  logic                reset,
    fetch_unit_if.master        imem,
    input  logic                redirect_valid,
    input  logic [31:0]         redirect_pc,
    input  logic                stall,
    output logic                inst_valid,
    output logic [31:0]         inst,
    output logic [31:0]         inst_pc
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef logic [AW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;
    typedef logic [CW:0]   wide_t;

    logic [31:0]      fetch_pc_q;
    ptr_t             head_q;
    ptr_t             tail_q;
    ptr_t             fill_q;
    cnt_t             alloc_cnt_q;
    cnt_t             pend_cnt_q;
    cnt_t             drop_cnt_q;
    logic [DEPTH-1:0] filled_q;
    logic [31:0]      last_pc_q;
    logic [31:0]      pc_q   [DEPTH];
    logic [31:0]      data_q [DEPTH];

    wide_t credit;
    logic  req_ok;
    logic  accept;
    logic  drop_fire;
    logic  fill_fire;
    logic  consume;

    // Credits cover both live entries and stale responses still owed by memory.
    assign credit    = {1'b0, alloc_cnt_q} + {1'b0, drop_cnt_q};
    assign req_ok    = !reset && !redirect_valid && (credit < wide_t'(DEPTH));
    assign accept    = req_ok && imem.imem_req_ready;
    assign drop_fire = imem.imem_resp_valid && (drop_cnt_q != '0);
    assign fill_fire = imem.imem_resp_valid && (drop_cnt_q == '0) && (pend_cnt_q != '0);

    assign imem.imem_req_valid = req_ok;
    assign imem.imem_req_addr  = fetch_pc_q;

    assign inst_valid = (alloc_cnt_q != '0) && filled_q[head_q];
    assign consume    = inst_valid && !stall;
    assign inst       = inst_valid ? data_q[head_q] : NOP;
    assign inst_pc    = inst_valid ? pc_q[head_q] : last_pc_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q  <= RESET_PC;
            head_q      <= '0;
            tail_q      <= '0;
            fill_q      <= '0;
            alloc_cnt_q <= '0;
            pend_cnt_q  <= '0;
            drop_cnt_q  <= '0;
            filled_q    <= '0;
            last_pc_q   <= '0;
        end else begin
            if (inst_valid) begin
                last_pc_q <= pc_q[head_q];
            end
            if (redirect_valid) begin
                // Unfilled entries become stale responses; one arriving now is already accounted for.
                fetch_pc_q  <= redirect_pc & 32'hFFFF_FFFC;
                head_q      <= tail_q;
                fill_q      <= tail_q;
                alloc_cnt_q <= '0;
                pend_cnt_q  <= '0;
                drop_cnt_q  <= drop_cnt_q + pend_cnt_q - cnt_t'(drop_fire || fill_fire);
            end else begin
                if (accept) begin
                    fetch_pc_q       <= fetch_pc_q + 32'd4;
                    tail_q           <= tail_q + ptr_t'(1);
                    filled_q[tail_q] <= 1'b0;
                end
                if (fill_fire) begin
                    filled_q[fill_q] <= 1'b1;
                    fill_q           <= fill_q + ptr_t'(1);
                end
                if (drop_fire) begin
                    drop_cnt_q <= drop_cnt_q - cnt_t'(1);
                end
                if (consume) begin
                    head_q <= head_q + ptr_t'(1);
                end
                alloc_cnt_q <= alloc_cnt_q + cnt_t'(accept) - cnt_t'(consume);
                pend_cnt_q  <= pend_cnt_q + cnt_t'(accept) - cnt_t'(fill_fire);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            pc_q[tail_q] <= fetch_pc_q;
        end
        if (fill_fire && !redirect_valid) begin
            data_q[fill_q] <= imem.imem_resp_data;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit with an in-order variable-latency memory model
module tb_fetch_unit;
    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    fetch_unit_if imem_bus();

    fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0), .NOP(NOP)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem           (imem_bus),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    typedef struct {
        bit          rst;
        bit          stall;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_iv;
        logic [31:0] e_pc;
    } vec_t;

    mreq_t mq[$];
    vec_t  vt[$];
    int    n_checks;
    int    n_fail;
    int    cyc;
    int    lat;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic present();
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_bus.imem_resp_valid = 1'b1;
            imem_bus.imem_resp_data  = mem_word(mq[0].addr);
        end else begin
            imem_bus.imem_resp_valid = 1'b0;
            imem_bus.imem_resp_data  = 32'h0;
        end
        #1;
    endtask

    task automatic tick();
        logic  acc;
        mreq_t r;
        acc = imem_bus.imem_req_valid && imem_bus.imem_req_ready;
        if (imem_bus.imem_resp_valid) void'(mq.pop_front());
        if (acc) begin
            r.addr = imem_bus.imem_req_addr;
            r.due  = cyc + lat;
            if (mq.size() > 0 && mq[$].due >= r.due) r.due = mq[$].due + 1;
            mq.push_back(r);
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset(input int hold);
        reset = 1'b1;
        redirect_valid = 1'b0;
        stall = 1'b0;
        imem_bus.imem_req_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            present();
            tick();
        end
        mq.delete();
        reset = 1'b0;
        cyc = 0;
    endtask

    task automatic add_vec(input bit r, input bit s, input bit er, input logic [31:0] ea,
                           input bit ev, input logic [31:0] ep);
        vec_t v;
        v.rst = r; v.stall = s; v.e_req = er; v.e_addr = ea; v.e_iv = ev; v.e_pc = ep;
        vt.push_back(v);
    endtask

    task automatic wait_first(input string name, input logic [31:0] exp_pc);
        bit found;
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            present();
            if (inst_valid) begin
                found = 1'b1;
                check({name, "_pc"}, inst_pc, exp_pc);
                check({name, "_inst"}, inst, mem_word(exp_pc));
            end
            tick();
        end
        check({name, "_found"}, found, 1);
    endtask

    initial begin
        logic [31:0] exp_req, exp_pc, prev_addr;
        bit          prev_req, prev_acc, prev_redir;
        int          consumed;

        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; stall = 1'b0;
        imem_bus.imem_req_ready = 1'b0; imem_bus.imem_resp_valid = 1'b0; imem_bus.imem_resp_data = 32'h0;
        n_checks = 0; n_fail = 0; cyc = 0; lat = 1;
        @(negedge clk);
        #1;
        check("reset_req_valid", imem_bus.imem_req_valid, 0);
        check("reset_inst_valid", inst_valid, 0);
        check("reset_inst", inst, NOP);
        check("reset_inst_pc", inst_pc, 0);

        // Startup with 1-cycle memory, then stall-fill and drain.
        add_vec(1, 0, 1, 32'h00, 0, 32'h00);
        add_vec(0, 0, 1, 32'h04, 0, 32'h00);
        add_vec(0, 0, 1, 32'h08, 1, 32'h00);
        add_vec(0, 0, 1, 32'h0C, 1, 32'h04);
        add_vec(0, 0, 1, 32'h10, 1, 32'h08);
        add_vec(0, 0, 1, 32'h14, 1, 32'h0C);
        add_vec(1, 1, 1, 32'h00, 0, 32'h00);
        add_vec(0, 1, 1, 32'h04, 0, 32'h00);
        add_vec(0, 1, 1, 32'h08, 1, 32'h00);
        add_vec(0, 1, 1, 32'h0C, 1, 32'h00);
        for (int i = 0; i < 6; i++) add_vec(0, 1, 0, 32'h00, 1, 32'h00);
        add_vec(0, 0, 0, 32'h00, 1, 32'h00);
        add_vec(0, 0, 1, 32'h10, 1, 32'h04);
        add_vec(0, 0, 1, 32'h14, 1, 32'h08);
        add_vec(0, 0, 1, 32'h18, 1, 32'h0C);
        add_vec(0, 0, 1, 32'h1C, 1, 32'h10);

        lat = 1;
        for (int i = 0; i < vt.size(); i++) begin
            if (vt[i].rst) do_reset(3);
            stall = vt[i].stall;
            imem_bus.imem_req_ready = 1'b1;
            present();
            check($sformatf("vec%0d_req_valid", i), imem_bus.imem_req_valid, vt[i].e_req);
            if (vt[i].e_req) check($sformatf("vec%0d_req_addr", i), imem_bus.imem_req_addr, vt[i].e_addr);
            check($sformatf("vec%0d_inst_valid", i), inst_valid, vt[i].e_iv);
            check($sformatf("vec%0d_inst_pc", i), inst_pc, vt[i].e_pc);
            check($sformatf("vec%0d_inst", i), inst, vt[i].e_iv ? mem_word(vt[i].e_pc) : NOP);
            tick();
        end

        // Redirect with two stale requests in flight on a 3-cycle memory.
        lat = 3;
        do_reset(3);
        imem_bus.imem_req_ready = 1'b1;
        present(); tick();
        present(); tick();
        imem_bus.imem_req_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        present();
        check("redir_no_req", imem_bus.imem_req_valid, 0);
        tick();
        redirect_valid = 1'b0;
        imem_bus.imem_req_ready = 1'b1;
        present();
        check("redir_req_addr", imem_bus.imem_req_addr, 32'h100);
        tick();
        wait_first("redir100", 32'h100);

        // Unaligned redirect target.
        lat = 1;
        for (int i = 0; i < 4; i++) begin present(); tick(); end
        redirect_valid = 1'b1; redirect_pc = 32'h203;
        present(); tick();
        redirect_valid = 1'b0;
        present();
        check("align_req_valid", imem_bus.imem_req_valid, 1);
        check("align_req_addr", imem_bus.imem_req_addr, 32'h200);
        tick();
        wait_first("redir200", 32'h200);

        // Redirect coinciding with a response and a consume.
        do_reset(3);
        imem_bus.imem_req_ready = 1'b1;
        present(); tick();
        present(); tick();
        redirect_valid = 1'b1; redirect_pc = 32'h300;
        present();
        check("rrc_inst_valid_before", inst_valid, 1);
        tick();
        redirect_valid = 1'b0;
        present();
        check("rrc_inst_valid_after", inst_valid, 0);
        check("rrc_inst_after", inst, NOP);
        tick();
        wait_first("redir300", 32'h300);

        // Reset asserted mid-stream with requests in flight.
        lat = 3;
        do_reset(3);
        imem_bus.imem_req_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin present(); tick(); end
        present();
        #2 reset = 1'b1;
        #1;
        check("midrst_req_valid", imem_bus.imem_req_valid, 0);
        check("midrst_inst_valid", inst_valid, 0);
        check("midrst_inst", inst, NOP);
        check("midrst_inst_pc", inst_pc, 0);
        do_reset(5);
        imem_bus.imem_req_ready = 1'b1;
        present();
        check("midrst_restart_valid", imem_bus.imem_req_valid, 1);
        check("midrst_restart_addr", imem_bus.imem_req_addr, 32'h0);
        tick();
        wait_first("midrst_first", 32'h0);

        // Randomised run against a sequential-PC reference.
        do_reset(2);
        exp_req = 32'h0; exp_pc = 32'h0; consumed = 0;
        prev_req = 1'b0; prev_acc = 1'b0; prev_redir = 1'b0; prev_addr = 32'h0;
        for (int t = 0; t < 10000; t++) begin
            imem_bus.imem_req_ready = ($urandom_range(0, 3) != 0);
            stall = ($urandom_range(0, 9) < 3);
            redirect_valid = ($urandom_range(0, 39) == 0);
            redirect_pc = $urandom;
            lat = $urandom_range(1, 4);
            present();
            if (prev_req && !prev_acc && !prev_redir && !redirect_valid)
                check("rnd_req_hold", {imem_bus.imem_req_valid, imem_bus.imem_req_addr}, {1'b1, prev_addr});
            check("rnd_inst", inst, inst_valid ? mem_word(inst_pc) : NOP);
            if (imem_bus.imem_req_valid && imem_bus.imem_req_ready) begin
                check("rnd_req_addr", imem_bus.imem_req_addr, exp_req);
                exp_req = exp_req + 32'd4;
            end
            if (inst_valid && !stall && !redirect_valid) begin
                check("rnd_inst_pc", inst_pc, exp_pc);
                exp_pc = exp_pc + 32'd4;
                consumed++;
            end
            if (redirect_valid) begin
                exp_req = redirect_pc & 32'hFFFF_FFFC;
                exp_pc  = redirect_pc & 32'hFFFF_FFFC;
            end
            prev_req   = imem_bus.imem_req_valid;
            prev_acc   = imem_bus.imem_req_valid && imem_bus.imem_req_ready;
            prev_redir = redirect_valid;
            prev_addr  = imem_bus.imem_req_addr;
            tick();
            check("rnd_outstanding", (mq.size() <= DEPTH), 1);
        end
        check("rnd_progress", (consumed >= 1000), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
